// File: rtl/snake_pkg.sv
// ============================================================================
// Module : snake_pkg
// Shared direction, cell and FSM state encodings for the snake body engine.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package snake_pkg;
   localparam logic [1:0] DIR_UP    = 2'b00;
   localparam logic [1:0] DIR_RIGHT = 2'b01;
   localparam logic [1:0] DIR_DOWN  = 2'b10;
   localparam logic [1:0] DIR_LEFT  = 2'b11;

   localparam logic [1:0] CELL_EMPTY = 2'b00;
   localparam logic [1:0] CELL_SNAKE = 2'b01;
   localparam logic [1:0] CELL_APPLE = 2'b10;
   localparam logic [1:0] CELL_BLOCK = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_CHECK = 2'd1,
      ST_SHIFT = 2'd2,
      ST_DEAD  = 2'd3
   } state_t;
endpackage

`default_nettype wire

// File: rtl/snake_head_step.sv
// ============================================================================
// Module : snake_head_step
// Combinational next-head computation with toroidal wrap-around.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module snake_head_step
   import snake_pkg::*;
#(
   parameter int SIZE_X = 10,
   parameter int SIZE_Y = 10
) (
   input  logic [7:0] i_x,
   input  logic [7:0] i_y,
   input  logic [1:0] i_dir,
   output logic [7:0] o_x,
   output logic [7:0] o_y
);
   localparam logic [7:0] c_max_x = 8'(SIZE_X - 1);
   localparam logic [7:0] c_max_y = 8'(SIZE_Y - 1);

   always_comb begin
      o_x = i_x;
      o_y = i_y;
      case (i_dir)
         DIR_UP:    o_y = (i_y == 8'd0)    ? c_max_y : i_y - 8'd1;
         DIR_RIGHT: o_x = (i_x == c_max_x) ? 8'd0    : i_x + 8'd1;
         DIR_DOWN:  o_y = (i_y == c_max_y) ? 8'd0    : i_y + 8'd1;
         default:   o_x = (i_x == 8'd0)    ? c_max_x : i_x - 8'd1;
      endcase
   end
endmodule

`default_nettype wire

// File: rtl/snake_move.sv
// ============================================================================
// Module : snake_move
// Snake body engine: head advance, target-cell classification, body shift.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module snake_move
   import snake_pkg::*;
#(
   parameter int SIZE_X     = 10,
   parameter int SIZE_Y     = 10,
   parameter int INIT_LEN   = 3,
   parameter int MAX_LEN    = SIZE_X * SIZE_Y,
   parameter int SNAKE_SIZE = 8 * (SIZE_X * SIZE_Y) * 2,
   parameter int FIELD_SIZE = (SIZE_X * SIZE_Y) * 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  step,
   input  logic [1:0]            dir,
   input  logic [FIELD_SIZE-1:0] field,
   output logic [SNAKE_SIZE-1:0] snake_xy,
   output logic [15:0]           lengh,
   output logic                  grow,
   output logic                  game_over,
   output logic                  busy
);
   localparam int          c_cells   = SIZE_X * SIZE_Y;
   localparam logic [15:0] c_max_len = 16'(MAX_LEN);

   state_t      r_state, w_state_nxt;
   logic [7:0]  r_seg_x [c_cells];
   logic [7:0]  r_seg_y [c_cells];
   logic [15:0] r_len;
   logic [1:0]  r_cur_dir, r_pend_dir;
   logic [7:0]  r_nh_x, r_nh_y;
   logic        r_eat, r_grow, r_game_over;

   logic [7:0]  w_nh_x, w_nh_y, w_tail_x, w_tail_y;
   logic [15:0] w_idx;
   logic [1:0]  w_cell;
   logic        w_collide, w_busy;

   snake_head_step #(.SIZE_X(SIZE_X), .SIZE_Y(SIZE_Y)) u_head_step (
      .i_x   (r_seg_x[0]),
      .i_y   (r_seg_y[0]),
      .i_dir (r_pend_dir),
      .o_x   (w_nh_x),
      .o_y   (w_nh_y)
   );

   // Constant-index scans keep the lookups free of wide variable selects.
   always_comb begin
      w_idx    = 16'(w_nh_x) + 16'(w_nh_y) * 16'(SIZE_X);
      w_cell   = CELL_EMPTY;
      w_tail_x = 8'd0;
      w_tail_y = 8'd0;
      for (int i = 0; i < c_cells; i++) begin
         if (16'(i) == w_idx)
            w_cell = field[2*i +: 2];
         if (16'(i) == r_len - 16'd1) begin
            w_tail_x = r_seg_x[i];
            w_tail_y = r_seg_y[i];
         end
      end
      // The tail vacates its cell during the same shift, so entering it is legal.
      w_collide = (w_cell == CELL_BLOCK) ||
                  ((w_cell == CELL_SNAKE) && !((w_nh_x == w_tail_x) && (w_nh_y == w_tail_y)));
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= ST_IDLE;
      else      r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_busy      = 1'b0;
      case (r_state)
         ST_IDLE:  if (step) w_state_nxt = ST_CHECK;
         ST_CHECK: begin
            w_busy      = 1'b1;
            w_state_nxt = w_collide ? ST_DEAD : ST_SHIFT;
         end
         ST_SHIFT: begin
            w_busy      = 1'b1;
            w_state_nxt = ST_IDLE;
         end
         default:  w_state_nxt = ST_DEAD;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int k = 0; k < c_cells; k++) begin
            r_seg_x[k] <= (k < INIT_LEN) ? 8'(SIZE_X/2 - k) : 8'd0;
            r_seg_y[k] <= (k < INIT_LEN) ? 8'(SIZE_Y/2)     : 8'd0;
         end
         r_len       <= 16'(INIT_LEN);
         r_cur_dir   <= DIR_RIGHT;
         r_pend_dir  <= DIR_RIGHT;
         r_nh_x      <= 8'd0;
         r_nh_y      <= 8'd0;
         r_eat       <= 1'b0;
         r_grow      <= 1'b0;
         r_game_over <= 1'b0;
      end else begin
         r_grow <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (dir != (r_cur_dir ^ 2'b10))
                  r_pend_dir <= dir;
            end
            ST_CHECK: begin
               r_cur_dir <= r_pend_dir;
               r_nh_x    <= w_nh_x;
               r_nh_y    <= w_nh_y;
               r_eat     <= (w_cell == CELL_APPLE);
               if (w_collide)
                  r_game_over <= 1'b1;
            end
            ST_SHIFT: begin
               for (int k = c_cells - 1; k >= 1; k--) begin
                  r_seg_x[k] <= r_seg_x[k-1];
                  r_seg_y[k] <= r_seg_y[k-1];
               end
               r_seg_x[0] <= r_nh_x;
               r_seg_y[0] <= r_nh_y;
               if (r_eat && (r_len < c_max_len))
                  r_len <= r_len + 16'd1;
               r_grow <= r_eat;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      snake_xy = '0;
      for (int k = 0; k < c_cells; k++) begin
         if (16'(k) < r_len)
            snake_xy[16*k +: 16] = {r_seg_y[k], r_seg_x[k]};
      end
   end

   assign lengh     = r_len;
   assign grow      = r_grow;
   assign game_over = r_game_over;
   assign busy      = w_busy;
endmodule

`default_nettype wire

// File: tb/tb_snake_move.sv
// ============================================================================
// Module : tb_snake_move
// Directed self-checking bench for the snake body engine (10x10 field).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_snake_move;
   logic          clk;
   logic          rst;
   logic          step;
   logic [1:0]    dir;
   logic [199:0]  field;
   logic [1599:0] snake_xy;
   logic [15:0]   lengh;
   logic          grow;
   logic          game_over;
   logic          busy;

   int checks = 0;
   int errors = 0;

   snake_move #(
      .SIZE_X(10), .SIZE_Y(10), .INIT_LEN(3)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .step      (step),
      .dir       (dir),
      .field     (field),
      .snake_xy  (snake_xy),
      .lengh     (lengh),
      .grow      (grow),
      .game_over (game_over),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", tag, act, exp);
      end
   endtask

   // Segment k packed as {y, x}.
   function automatic logic [15:0] seg(input int k);
      return snake_xy[16*k +: 16];
   endfunction

   task automatic set_cell(input int x, input int y, input logic [1:0] v);
      field[2*(x + 10*y) +: 2] = v;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
   endtask

   // Pulse step across edge E; returns at the negedge after E+2.
   task automatic do_step(input string tag);
      step = 1'b1;
      @(negedge clk);
      step = 1'b0;
      check({tag, "_busy_e1"}, 32'(busy), 32'd1);
      @(negedge clk);
      @(negedge clk);
   endtask

   initial begin
      rst   = 1'b0;
      step  = 1'b0;
      dir   = 2'b01;
      field = '0;
      do_reset();

      check("rst_seg0", 32'(seg(0)), 32'h0505);
      check("rst_seg1", 32'(seg(1)), 32'h0504);
      check("rst_seg2", 32'(seg(2)), 32'h0503);
      check("rst_seg3", 32'(seg(3)), 32'h0000);
      check("rst_len",  32'(lengh), 32'd3);
      check("rst_grow", 32'(grow), 32'd0);
      check("rst_go",   32'(game_over), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);

      do_step("right");
      check("right_seg0", 32'(seg(0)), 32'h0506);
      check("right_seg1", 32'(seg(1)), 32'h0505);
      check("right_seg2", 32'(seg(2)), 32'h0504);
      check("right_len",  32'(lengh), 32'd3);
      check("right_grow", 32'(grow), 32'd0);
      check("right_busy", 32'(busy), 32'd0);

      dir = 2'b11;
      repeat (2) @(negedge clk);
      do_step("rev");
      check("rev_seg0", 32'(seg(0)), 32'h0507);
      dir = 2'b01;

      // Second step pulse lands in CHECK and must be dropped.
      step = 1'b1;
      repeat (2) @(negedge clk);
      step = 1'b0;
      repeat (4) @(negedge clk);
      check("busy_ign_seg0", 32'(seg(0)), 32'h0508);
      check("busy_ign_seg1", 32'(seg(1)), 32'h0507);

      do_step("wrap_r1");
      do_step("wrap_r2");
      check("wrapx_seg0", 32'(seg(0)), 32'h0500);
      check("wrapx_seg1", 32'(seg(1)), 32'h0509);

      do_reset();
      set_cell(6, 5, 2'b10);
      do_step("apple");
      check("apple_seg0", 32'(seg(0)), 32'h0506);
      check("apple_seg3", 32'(seg(3)), 32'h0503);
      check("apple_len",  32'(lengh), 32'd4);
      check("apple_grow", 32'(grow), 32'd1);
      @(negedge clk);
      check("apple_grow_off", 32'(grow), 32'd0);
      field = '0;

      do_reset();
      dir = 2'b00;
      for (int i = 0; i < 5; i++) do_step("up");
      check("up_y0_seg0", 32'(seg(0)), 32'h0005);
      do_step("up_wrap");
      check("wrapy_seg0", 32'(seg(0)), 32'h0905);
      dir = 2'b01;

      do_reset();
      set_cell(6, 5, 2'b11);
      do_step("block");
      check("block_go",   32'(game_over), 32'd1);
      check("block_seg0", 32'(seg(0)), 32'h0505);
      check("block_len",  32'(lengh), 32'd3);
      check("block_busy", 32'(busy), 32'd0);
      field = '0;
      step = 1'b1;
      @(negedge clk);
      step = 1'b0;
      repeat (3) @(negedge clk);
      check("dead_seg0", 32'(seg(0)), 32'h0505);
      check("dead_go",   32'(game_over), 32'd1);

      do_reset();
      check("rst2_go", 32'(game_over), 32'd0);
      set_cell(6, 5, 2'b01);
      do_step("body");
      check("body_go",   32'(game_over), 32'd1);
      check("body_seg0", 32'(seg(0)), 32'h0505);
      field = '0;

      do_reset();
      set_cell(6, 5, 2'b10);
      step = 1'b1;
      @(negedge clk);
      step = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("midrst_len",  32'(lengh), 32'd3);
      check("midrst_seg0", 32'(seg(0)), 32'h0505);
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_go",   32'(game_over), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check("midrst_len2",  32'(lengh), 32'd3);
      check("midrst_grow2", 32'(grow), 32'd0);
      check("midrst_seg0b", 32'(seg(0)), 32'h0505);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

`default_nettype wire
